// File: rtl/rr_out_allocator_if.sv
// Flit-side handshake bundle between the input channels, the output mux and the
// per-output allocator. The slave modport is the allocator's view.
interface rr_out_allocator_if #(
  parameter int unsigned PORTS = 4,
  parameter int unsigned ADR_W = $clog2(PORTS)
);
  logic [PORTS-1:0][3:0] in_ch_hdr_msn;
  logic                  out_rdy;
  logic [PORTS-1:0]      sel;
  logic                  shift;
  logic                  busy;
  logic [ADR_W-1:0]      owner;
  logic                  err_timeout;

  modport master (
    output in_ch_hdr_msn, out_rdy,
    input  sel, shift, busy, owner, err_timeout
  );

  modport slave (
    input  in_ch_hdr_msn, out_rdy,
    output sel, shift, busy, owner, err_timeout
  );
endinterface

// File: rtl/rr_out_allocator.sv
// Per-output round-robin allocator: grants a header to one input, holds the output
// for that packet's payload, and reclaims the port if a packet runs too long.
module rr_out_allocator #(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned ADR_W   = $clog2(PORTS),
  parameter int unsigned MAX_PKT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] r_adr,
  rr_out_allocator_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = ADR_W + 1;
  localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(MAX_PKT);
  localparam logic [IDX_W-1:0] PORTS_X   = IDX_W'(PORTS);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e           state_q, state_d;
  logic [ADR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ADR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [PORTS-1:0] req, pay;
  logic [ADR_W-1:0] winner;
  logic             found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] winner_inc;
  logic [ADR_W-1:0] winner_nxt;
  logic [PORTS-1:0] sel_c;
  logic             shift_c, busy_c, err_c;

  // Header/MSN decode per input channel
  always_comb begin
    req = '0;
    pay = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      req[i] = (bus.in_ch_hdr_msn[i][3:2] == 2'b11) &&
               (ADR_W'(bus.in_ch_hdr_msn[i][1:0]) == r_adr);
      pay[i] = (bus.in_ch_hdr_msn[i][3:2] == 2'b10);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo PORTS
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      cand = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (cand >= PORTS_X) begin
        cand = cand - PORTS_X;
      end
      if (!found && req[cand[ADR_W-1:0]]) begin
        winner = cand[ADR_W-1:0];
        found  = 1'b1;
      end
    end
    winner_inc = {1'b0, winner} + IDX_W'(1);
    winner_nxt = (winner_inc >= PORTS_X) ? '0 : winner_inc[ADR_W-1:0];
  end

  // Next-state and combinational outputs; everything is forced idle during reset
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    sel_c      = '0;
    shift_c    = 1'b0;
    busy_c     = 1'b0;
    err_c      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (found) begin
            sel_c[winner] = 1'b1;
            shift_c       = bus.out_rdy;
            if (bus.out_rdy) begin
              owner_d    = winner;
              rr_ptr_d   = winner_nxt;
              beat_cnt_d = '0;
              state_d    = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          busy_c = 1'b1;
          if (!pay[owner_q]) begin
            state_d = ST_IDLE;
          end else if (beat_cnt_q >= MAX_BEATS) begin
            err_c   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sel_c[owner_q] = 1'b1;
            shift_c        = bus.out_rdy;
            if (bus.out_rdy) begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.sel         = sel_c;
  assign bus.shift       = shift_c;
  assign bus.busy        = busy_c;
  assign bus.owner       = owner_q;
  assign bus.err_timeout = err_c;

endmodule

// File: tb/tb_rr_out_allocator.sv
// Bench for rr_out_allocator: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_rr_out_allocator;

  localparam int unsigned PORTS   = 4;
  localparam int unsigned ADR_W   = 2;
  localparam int unsigned MAX_PKT = 4;

  localparam logic [3:0] N  = 4'b0000;
  localparam logic [3:0] P  = 4'b1000;
  localparam logic [3:0] RV = 4'b0110;
  localparam logic [3:0] HR = 4'b1110;  // header to address 2 (this output)
  localparam logic [3:0] H1 = 4'b1101;  // header to address 1

  typedef logic [PORTS-1:0][3:0] msn_t;

  typedef struct {
    bit         r;
    msn_t       msn;
    bit         rdy;
    logic [3:0] sel;
    bit         sh;
    bit         bsy;
    int         own;
    bit         err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ADR_W-1:0] r_adr = 2'd2;

  rr_out_allocator_if #(.PORTS(PORTS), .ADR_W(ADR_W)) bus ();

  rr_out_allocator #(.PORTS(PORTS), .ADR_W(ADR_W), .MAX_PKT(MAX_PKT)) dut (
    .clk  (clk),
    .rst  (rst),
    .r_adr(r_adr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] act_sel;
  logic       act_shift, act_busy, act_err;
  logic [1:0] act_owner;

  logic [3:0] exp_sel;
  bit         exp_shift, exp_busy, exp_err;
  int         exp_owner;

  // Reference model state: who owns the port, where priority starts, beats sent
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  vec_t       tbl[18];
  logic [3:0] t4_sel[7];
  bit         t4_sh[7];
  bit         t4_err[7];

  function automatic msn_t m4(input logic [3:0] n3, input logic [3:0] n2,
                              input logic [3:0] n1, input logic [3:0] n0);
    msn_t m;
    m[3] = n3; m[2] = n2; m[1] = n1; m[0] = n0;
    return m;
  endfunction

  function automatic vec_t v(input bit r, input msn_t m, input bit rdy, input logic [3:0] s,
                             input bit sh, input bit b, input int o, input bit e);
    vec_t t;
    t.r = r; t.msn = m; t.rdy = rdy; t.sel = s; t.sh = sh; t.bsy = b; t.own = o; t.err = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs for this cycle from the packet-level rules, then advance one clock
  task automatic model_step(input msn_t msn, input bit rdy, input bit r);
    int  win;
    int  i;
    bit  found;
    exp_sel   = 4'b0000;
    exp_shift = 1'b0;
    exp_busy  = 1'b0;
    exp_err   = 1'b0;
    exp_owner = m_owner;
    if (r) begin
      m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
      return;
    end
    if (!m_busy) begin
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < PORTS; k++) begin
        i = (m_ptr + k) % PORTS;
        if (!found && msn[i][3:2] == 2'b11 && msn[i][1:0] == r_adr) begin
          found = 1'b1;
          win   = i;
        end
      end
      if (found) begin
        exp_sel   = 4'(1 << win);
        exp_shift = rdy;
        if (rdy) begin
          m_busy = 1'b1; m_owner = win; m_ptr = (win + 1) % PORTS; m_beats = 0;
        end
      end
    end else begin
      exp_busy = 1'b1;
      if (msn[m_owner][3:2] != 2'b10) begin
        m_busy = 1'b0;
      end else if (m_beats >= MAX_PKT) begin
        exp_err = 1'b1;
        m_busy  = 1'b0;
      end else begin
        exp_sel   = 4'(1 << m_owner);
        exp_shift = rdy;
        if (rdy) m_beats++;
      end
    end
  endtask

  // Drive one cycle at the falling edge, sample outputs 1ns later, then clock it in
  task automatic apply(input msn_t msn, input bit rdy, input bit r);
    @(negedge clk);
    bus.in_ch_hdr_msn = msn;
    bus.out_rdy       = rdy;
    rst               = r;
    #1;
    act_sel   = bus.sel;
    act_shift = bus.shift;
    act_busy  = bus.busy;
    act_owner = bus.owner;
    act_err   = bus.err_timeout;
    model_step(msn, rdy, r);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    msn_t       m;
    bit         rdy, r;
    int         ph[PORTS];
    int         order[$];
    int         idx0, idx1, pays, g;

    bus.in_ch_hdr_msn = '0;
    bus.out_rdy       = 1'b0;
    apply(m4(N, N, N, N), 1'b1, 1'b1);
    apply(m4(N, N, N, N), 1'b1, 1'b1);

    // Directed table: single packet, out_rdy stalls + watchdog, ignored traffic
    tbl[0]  = v(1, m4(N, N, N, N),   1, 4'b0000, 0, 0, 0, 0);
    tbl[1]  = v(0, m4(N, N, HR, N),  1, 4'b0010, 1, 0, 0, 0);
    tbl[2]  = v(0, m4(N, N, P, N),   1, 4'b0010, 1, 1, 1, 0);
    tbl[3]  = v(0, m4(N, N, P, N),   1, 4'b0010, 1, 1, 1, 0);
    tbl[4]  = v(0, m4(N, N, P, N),   1, 4'b0010, 1, 1, 1, 0);
    tbl[5]  = v(0, m4(N, N, N, N),   1, 4'b0000, 0, 1, 1, 0);
    tbl[6]  = v(0, m4(N, N, N, N),   1, 4'b0000, 0, 0, 1, 0);
    tbl[7]  = v(0, m4(N, HR, N, N),  1, 4'b0100, 1, 0, 1, 0);
    tbl[8]  = v(0, m4(N, P, N, N),   1, 4'b0100, 1, 1, 2, 0);
    tbl[9]  = v(0, m4(N, P, N, N),   0, 4'b0100, 0, 1, 2, 0);
    tbl[10] = v(0, m4(N, P, N, N),   1, 4'b0100, 1, 1, 2, 0);
    tbl[11] = v(0, m4(N, P, N, N),   1, 4'b0100, 1, 1, 2, 0);
    tbl[12] = v(0, m4(N, P, N, N),   1, 4'b0100, 1, 1, 2, 0);
    tbl[13] = v(0, m4(N, P, N, N),   1, 4'b0000, 0, 1, 2, 1);
    tbl[14] = v(0, m4(N, P, N, N),   1, 4'b0000, 0, 0, 2, 0);
    tbl[15] = v(0, m4(H1, N, N, P),  1, 4'b0000, 0, 0, 2, 0);
    tbl[16] = v(0, m4(H1, RV, N, P), 1, 4'b0000, 0, 0, 2, 0);
    tbl[17] = v(0, m4(H1, N, P, P),  0, 4'b0000, 0, 0, 2, 0);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].msn, tbl[i].rdy, tbl[i].r);
      chk($sformatf("vec%0d sel", i),   act_sel,   tbl[i].sel);
      chk($sformatf("vec%0d shift", i), act_shift, tbl[i].sh);
      chk($sformatf("vec%0d busy", i),  act_busy,  tbl[i].bsy);
      chk($sformatf("vec%0d owner", i), act_owner, tbl[i].own);
      chk($sformatf("vec%0d err", i),   act_err,   tbl[i].err);
    end

    // Fairness: all inputs stream header/1-beat packets continuously
    apply(m4(N, N, N, N), 1'b1, 1'b1);
    for (int i = 0; i < PORTS; i++) ph[i] = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      for (int i = 0; i < PORTS; i++) m[i] = (ph[i] == 0) ? HR : P;
      apply(m, 1'b1, 1'b0);
      if (act_shift && !act_busy) begin
        g = -1;
        for (int i = 0; i < PORTS; i++) if (act_sel[i]) g = i;
        order.push_back(g);
      end
      for (int i = 0; i < PORTS; i++) if (act_shift && act_sel[i]) ph[i] ^= 1;
    end
    chk("rr grant count", order.size(), 5);
    for (int k = 0; k < order.size(); k++) chk($sformatf("rr grant%0d", k), order[k], k % PORTS);

    // Watchdog: input 0 overruns MAX_PKT while input 1 waits with a header
    t4_sel = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    t4_sh  = '{1, 1, 1, 1, 1, 0, 1};
    t4_err = '{0, 0, 0, 0, 0, 1, 0};
    apply(m4(N, N, N, N), 1'b1, 1'b1);
    idx0 = 0; idx1 = 0; pays = 0;
    for (int c = 0; c < 7; c++) begin
      m    = m4(N, N, N, N);
      m[0] = (idx0 == 0) ? HR : ((idx0 <= 6) ? P : N);
      m[1] = (idx1 == 0) ? HR : N;
      apply(m, 1'b1, 1'b0);
      chk($sformatf("wd c%0d sel", c),   act_sel,   t4_sel[c]);
      chk($sformatf("wd c%0d shift", c), act_shift, t4_sh[c]);
      chk($sformatf("wd c%0d err", c),   act_err,   t4_err[c]);
      if (act_shift && act_busy && act_sel[0]) pays++;
      if (act_shift && act_sel[0]) idx0++;
      if (act_shift && act_sel[1]) idx1++;
    end
    chk("wd payload shifts", pays, MAX_PKT);

    // Reset mid-packet restarts arbitration from input 0
    apply(m4(N, N, N, N), 1'b1, 1'b1);
    apply(m4(HR, N, N, N), 1'b1, 1'b0);
    chk("rst3 grant sel", act_sel, 4'b1000);
    apply(m4(P, N, N, N), 1'b1, 1'b0);
    chk("rst3 owner", act_owner, 3);
    apply(m4(P, N, N, N), 1'b1, 1'b1);
    chk("rst3 sel", act_sel, 4'b0000);
    chk("rst3 shift", act_shift, 0);
    chk("rst3 busy", act_busy, 0);
    chk("rst3 err", act_err, 0);
    apply(m4(HR, N, N, HR), 1'b1, 1'b0);
    chk("rst3 regrant sel", act_sel, 4'b0001);
    chk("rst3 regrant shift", act_shift, 1);
    apply(m4(N, N, N, N), 1'b1, 1'b0);
    apply(m4(N, N, N, N), 1'b1, 1'b0);
    apply(m4(N, N, HR, N), 1'b1, 1'b0);
    chk("rst1 grant sel", act_sel, 4'b0010);
    apply(m4(N, N, P, N), 1'b1, 1'b0);
    apply(m4(N, N, P, N), 1'b1, 1'b1);
    chk("rst1 busy", act_busy, 0);
    apply(m4(HR, N, N, HR), 1'b1, 1'b0);
    chk("rst1 regrant sel", act_sel, 4'b0001);

    // Randomized traffic against the reference model
    apply(m4(N, N, N, N), 1'b1, 1'b1);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < PORTS; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    m[i] = HR;
          2:       m[i] = {2'b11, 2'($urandom_range(0, 3))};
          3, 4, 5, 6, 7: m[i] = P;
          8:       m[i] = N;
          default: m[i] = {2'b01, 2'($urandom_range(0, 3))};
        endcase
      end
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 59) == 0);
      apply(m, rdy, r);
      chk($sformatf("rnd%0d sel", c),   act_sel,   exp_sel);
      chk($sformatf("rnd%0d shift", c), act_shift, exp_shift);
      chk($sformatf("rnd%0d busy", c),  act_busy,  exp_busy);
      chk($sformatf("rnd%0d owner", c), act_owner, exp_owner);
      chk($sformatf("rnd%0d err", c),   act_err,   exp_err);
      chk($sformatf("rnd%0d onehot", c), $onehot0(act_sel), 1);
      chk($sformatf("rnd%0d shift_ok", c), (!act_shift || ((|act_sel) && rdy)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
